// File: rtl/sequenciador_jogo_param.sv
// Memory-sequence game controller: shows a growing sequence on the LEDs, then
// checks the player's button presses against it, with optional lives and a per-play timeout.
module sequenciador_jogo_param #(
  parameter int NB          = 4,
  parameter int DEPTH       = 16,
  parameter int T_MOSTRA    = 500,
  parameter int T_INTERVALO = 500,
  parameter int T_TIMEOUT   = 3000,
  parameter int VIDAS       = 3,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic [NB-1:0] botoes,
  input  logic [NB-1:0] dado_mem,
  input  logic [1:0]    modo,
  output logic [AW-1:0] endereco,
  output logic [NB-1:0] leds,
  output logic [AW-1:0] rodada,
  output logic [2:0]    vidas_rest,
  output logic          pronto,
  output logic          acertou,
  output logic          errou,
  output logic          fim_timeout,
  output logic [3:0]    db_estado
);

  localparam int TMAX0 = (T_MOSTRA > T_INTERVALO) ? T_MOSTRA : T_INTERVALO;
  localparam int TMAX  = (TMAX0 > T_TIMEOUT) ? TMAX0 : T_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] FIM_MOSTRA    = TW'(T_MOSTRA - 1);
  localparam logic [TW-1:0] FIM_INTERVALO = TW'(T_INTERVALO - 1);
  localparam logic [TW-1:0] FIM_TIMEOUT   = TW'(T_TIMEOUT - 1);
  localparam logic [AW-1:0] ULT_CURTA     = AW'(DEPTH / 2 - 1);
  localparam logic [AW-1:0] ULT_LONGA     = AW'(DEPTH - 1);
  localparam logic [2:0]    VIDAS_INI     = 3'(VIDAS);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    PROXIMA_MOSTRA = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    ULTIMA         = 4'h7,
    PROXIMA_SEQ    = 4'h8,
    MOSTRA         = 4'h9,
    INTERVALO      = 4'hA,
    INICIA_SEQ     = 4'hB,
    PERDE_VIDA     = 4'hC,
    FINAL_TIMEOUT  = 4'hD,
    FINAL_ACERTOU  = 4'hE,
    FINAL_ERROU    = 4'hF
  } estadoT;

  estadoT        estado;
  logic [TW-1:0] tempo;
  logic          botoesAnt;
  logic          modoLongo;
  logic [NB-1:0] jogada;
  logic          jogadaNova;
  logic [AW-1:0] rodadaLim;

  function automatic logic [2:0] decSat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // A play is the rising edge of "any button pressed"
  assign jogadaNova = (|botoes) & ~botoesAnt;
  assign rodadaLim  = modoLongo ? ULT_LONGA : ULT_CURTA;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado     <= INICIAL;
      endereco   <= '0;
      rodada     <= '0;
      vidas_rest <= 3'd0;
      tempo      <= '0;
      modoLongo  <= 1'b0;
      botoesAnt  <= 1'b0;
    end else begin
      botoesAnt <= |botoes;
      case (estado)
        INICIAL: if (iniciar) estado <= PREPARACAO;
        PREPARACAO: begin
          rodada     <= '0;
          endereco   <= '0;
          tempo      <= '0;
          modoLongo  <= modo[0];
          vidas_rest <= modo[1] ? VIDAS_INI : 3'd1;
          estado     <= MOSTRA;
        end
        MOSTRA: begin
          if (tempo == FIM_MOSTRA) begin
            tempo  <= '0;
            estado <= INTERVALO;
          end else begin
            tempo <= tempo + TW'(1);
          end
        end
        INTERVALO: begin
          if (tempo == FIM_INTERVALO) begin
            tempo  <= '0;
            estado <= PROXIMA_MOSTRA;
          end else begin
            tempo <= tempo + TW'(1);
          end
        end
        PROXIMA_MOSTRA: begin
          if (endereco == rodada) begin
            endereco <= '0;
            estado   <= INICIA_SEQ;
          end else begin
            endereco <= endereco + AW'(1);
            estado   <= MOSTRA;
          end
        end
        INICIA_SEQ: begin
          tempo  <= '0;
          estado <= ESPERA;
        end
        // A play on the last allowed cycle beats the timeout
        ESPERA: begin
          if (jogadaNova)                 estado <= REGISTRA;
          else if (tempo == FIM_TIMEOUT)  estado <= FINAL_TIMEOUT;
          else                            tempo  <= tempo + TW'(1);
        end
        REGISTRA: estado <= COMPARA;
        COMPARA: begin
          if (jogada != dado_mem) begin
            estado <= PERDE_VIDA;
          end else if (endereco == rodada) begin
            estado <= ULTIMA;
          end else begin
            endereco <= endereco + AW'(1);
            estado   <= PROXIMA_JOGADA;
          end
        end
        PROXIMA_JOGADA: begin
          tempo  <= '0;
          estado <= ESPERA;
        end
        ULTIMA: estado <= (rodada == rodadaLim) ? FINAL_ACERTOU : PROXIMA_SEQ;
        PROXIMA_SEQ: begin
          rodada   <= rodada + AW'(1);
          endereco <= '0;
          tempo    <= '0;
          estado   <= MOSTRA;
        end
        // Losing a life replays the same round from its first item
        PERDE_VIDA: begin
          vidas_rest <= decSat(vidas_rest);
          if (vidas_rest <= 3'd1) begin
            estado <= FINAL_ERROU;
          end else begin
            endereco <= '0;
            tempo    <= '0;
            estado   <= MOSTRA;
          end
        end
        FINAL_TIMEOUT, FINAL_ACERTOU, FINAL_ERROU: if (iniciar) estado <= PREPARACAO;
        default: estado <= INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (estado == ESPERA && jogadaNova) jogada <= botoes;
  end

  always_comb begin
    leds = '0;
    case (estado)
      MOSTRA:                    leds = dado_mem;
      ESPERA, REGISTRA, COMPARA: leds = botoes;
      default: ;
    endcase
  end

  assign db_estado   = estado;
  assign acertou     = (estado == FINAL_ACERTOU);
  assign errou       = (estado == FINAL_ERROU);
  assign fim_timeout = (estado == FINAL_TIMEOUT);
  assign pronto      = acertou | errou | fim_timeout;

endmodule

// File: tb/tb_sequenciador_jogo_param.sv
// Scenario bench for sequenciador_jogo_param: scoreboards the LED display
// against a behavioural memory and drives complete games through every ending.
module tb_sequenciador_jogo_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [1:0] modo = 2'b00;
  logic [3:0] dado_mem, endereco, leds, rodada, db_estado;
  logic [2:0] vidas_rest;
  logic       pronto, acertou, errou, fim_timeout;

  logic [3:0] mem [16];
  assign dado_mem = mem[endereco];

  always #5 clock = ~clock;

  sequenciador_jogo_param #(
    .NB(4), .DEPTH(16), .T_MOSTRA(500), .T_INTERVALO(500), .T_TIMEOUT(3000), .VIDAS(3)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .dado_mem(dado_mem), .modo(modo), .endereco(endereco), .leds(leds),
    .rodada(rodada), .vidas_rest(vidas_rest), .pronto(pronto), .acertou(acertou),
    .errou(errou), .fim_timeout(fim_timeout), .db_estado(db_estado)
  );

  typedef struct {
    logic [3:0] val;
    int         onLen;
    int         offLen;
    bit         steady;
  } item_t;

  item_t expQ[$];
  item_t obsQ[$];
  int nChecks = 0;
  int nFails  = 0;

  logic [3:0] curVal = 4'd0;
  int         curOn = 0;
  int         curOff = 0;
  bit         curSteady = 1'b1;
  logic [3:0] prevEst = 4'd0;

  function automatic logic [3:0] wrongOf(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic clearTrack();
    curVal = 4'd0; curOn = 0; curOff = 0; curSteady = 1'b1; prevEst = 4'd0;
    obsQ.delete();
    expQ.delete();
  endtask

  // Advance to the next falling edge and record what the LEDs did
  task automatic step();
    @(negedge clock);
    if (db_estado === 4'h9) begin
      if (curOn == 0) curVal = leds;
      curOn++;
      if (leds !== dado_mem || leds !== curVal) curSteady = 1'b0;
    end else if (db_estado === 4'hA) begin
      curOff++;
      if (leds !== 4'd0) curSteady = 1'b0;
    end else if (prevEst === 4'hA) begin
      obsQ.push_back('{curVal, curOn, curOff, curSteady});
      curVal = 4'd0; curOn = 0; curOff = 0; curSteady = 1'b1;
    end
    prevEst = db_estado;
  endtask

  task automatic watchUntil(input logic [3:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (db_estado === code) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (db_estado === code) ok = 1'b1;
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    step();
    step();
    botoes = 4'd0;
    step();
  endtask

  task automatic startGame(input logic [1:0] m);
    modo = m;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic pushRound(input int r);
    for (int i = 0; i <= r; i++) expQ.push_back('{mem[i], 500, 500, 1'b1});
  endtask

  task automatic test_reset();
    step(); step();
    reset = 1'b1;
    clearTrack();
    nChecks++; if (db_estado !== 4'h0) begin nFails++; $display("FAIL reset_estado: got %h want 0", db_estado); end
    nChecks++; if (leds !== 4'd0) begin nFails++; $display("FAIL reset_leds: got %h want 0", leds); end
    nChecks++; if (endereco !== 4'd0) begin nFails++; $display("FAIL reset_endereco: got %h want 0", endereco); end
    nChecks++; if (rodada !== 4'd0) begin nFails++; $display("FAIL reset_rodada: got %h want 0", rodada); end
    nChecks++; if (vidas_rest !== 3'd0) begin nFails++; $display("FAIL reset_vidas: got %0d want 0", vidas_rest); end
    nChecks++; if ({pronto, acertou, errou, fim_timeout} !== 4'b0000) begin
      nFails++; $display("FAIL reset_flags: got %b want 0000", {pronto, acertou, errou, fim_timeout}); end
    for (int i = 0; i < 5; i++) step();
    nChecks++; if (db_estado !== 4'h0) begin nFails++; $display("FAIL idle_hold: got %h want 0", db_estado); end
  endtask

  task automatic test_round0_and_wrong();
    bit ok;
    item_t e, o;
    startGame(2'b00);
    nChecks++; if (db_estado !== 4'h1) begin nFails++; $display("FAIL prep_state: got %h want 1", db_estado); end
    pushRound(0);
    watchUntil(4'h3, 1100, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL round0_reach_espera: got %h want 3", db_estado); end
    nChecks++; if (obsQ.size() != expQ.size()) begin
      nFails++; $display("FAIL round0_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nChecks++;
      if (o.val !== e.val || o.onLen != e.onLen || o.offLen != e.offLen || o.steady != e.steady) begin
        nFails++;
        $display("FAIL round0_item: got val=%h on=%0d off=%0d steady=%0d want val=%h on=%0d off=%0d steady=1",
                 o.val, o.onLen, o.offLen, o.steady, e.val, e.onLen, e.offLen);
      end
    end
    clearTrack();
    nChecks++; if (vidas_rest !== 3'd1) begin nFails++; $display("FAIL single_life: got %0d want 1", vidas_rest); end
    botoes = wrongOf(mem[0]);
    step();
    nChecks++; if (db_estado !== 4'h4 || leds !== wrongOf(mem[0])) begin
      nFails++; $display("FAIL registra_echo: got state=%h leds=%h want state=4 leds=%h", db_estado, leds, wrongOf(mem[0])); end
    step();
    botoes = 4'd0;
    watchUntil(4'hF, 10, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL wrong_final: got %h want F", db_estado); end
    nChecks++; if ({pronto, acertou, errou, fim_timeout} !== 4'b1010 || vidas_rest !== 3'd0) begin
      nFails++; $display("FAIL errou_flags: got %b vidas=%0d want 1010 vidas=0", {pronto, acertou, errou, fim_timeout}, vidas_rest); end
    for (int i = 0; i < 5; i++) step();
    nChecks++; if (db_estado !== 4'hF) begin nFails++; $display("FAIL final_hold: got %h want F", db_estado); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    startGame(2'b00);
    watchUntil(4'h3, 1100, ok);
    clearTrack();
    nChecks++; if (!ok) begin nFails++; $display("FAIL timeout_reach_espera: got %h want 3", db_estado); end
    cnt = 0;
    while (db_estado === 4'h3 && cnt < 4000) begin
      cnt++;
      step();
    end
    nChecks++; if (cnt != 3000) begin nFails++; $display("FAIL timeout_cycles: got %0d want 3000", cnt); end
    nChecks++; if (db_estado !== 4'hD || {pronto, acertou, errou, fim_timeout} !== 4'b1001) begin
      nFails++; $display("FAIL timeout_final: got state=%h flags=%b want D 1001", db_estado, {pronto, acertou, errou, fim_timeout}); end
  endtask

  task automatic test_play_last_cycle();
    bit ok;
    startGame(2'b00);
    watchUntil(4'h3, 1100, ok);
    clearTrack();
    for (int i = 0; i < 2999; i++) step();
    nChecks++; if (db_estado !== 4'h3) begin nFails++; $display("FAIL late_still_espera: got %h want 3", db_estado); end
    botoes = mem[0];
    step();
    nChecks++; if (db_estado !== 4'h4 || leds !== mem[0]) begin
      nFails++; $display("FAIL late_play: got state=%h leds=%h want 4 %h", db_estado, leds, mem[0]); end
    step();
    botoes = 4'd0;
    watchUntil(4'h9, 10, ok);
    nChecks++; if (!ok || rodada !== 4'd1) begin
      nFails++; $display("FAIL next_round: got state=%h rodada=%0d want 9 1", db_estado, rodada); end
    for (int i = 0; i < 100; i++) step();
    reset = 1'b0;
    step();
    nChecks++; if (db_estado !== 4'h0 || leds !== 4'd0 || endereco !== 4'd0 || rodada !== 4'd0 ||
                   vidas_rest !== 3'd0 || {pronto, acertou, errou, fim_timeout} !== 4'b0000) begin
      nFails++; $display("FAIL reset_mostra: got state=%h leds=%h end=%h rod=%h vid=%0d want all 0",
                         db_estado, leds, endereco, rodada, vidas_rest); end
    reset = 1'b1;
    clearTrack();
  endtask

  task automatic test_reset_in_espera();
    bit ok;
    startGame(2'b10);
    watchUntil(4'h3, 1100, ok);
    clearTrack();
    nChecks++; if (!ok || vidas_rest !== 3'd3) begin
      nFails++; $display("FAIL lives_loaded: got state=%h vidas=%0d want 3 3", db_estado, vidas_rest); end
    for (int i = 0; i < 10; i++) step();
    botoes = 4'b0100;
    reset = 1'b0;
    step();
    nChecks++; if (db_estado !== 4'h0 || leds !== 4'd0 || vidas_rest !== 3'd0 || endereco !== 4'd0 ||
                   {pronto, acertou, errou, fim_timeout} !== 4'b0000) begin
      nFails++; $display("FAIL reset_espera: got state=%h leds=%h vid=%0d end=%h want all 0",
                         db_estado, leds, vidas_rest, endereco); end
    botoes = 4'd0;
    reset = 1'b1;
    step();
    clearTrack();
  endtask

  task automatic test_lives();
    bit ok;
    item_t e, o;
    startGame(2'b10);
    step(); step();
    modo = 2'b01;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i <= r; i++) begin
        watchUntil(4'h3, 2500, ok);
        nChecks++; if (!ok) begin nFails++; $display("FAIL lives_play_r%0d_i%0d: got %h want 3", r, i, db_estado); end
        press(mem[i]);
      end
    end
    watchUntil(4'h3, 3500, ok);
    clearTrack();
    nChecks++; if (!ok || vidas_rest !== 3'd3 || rodada !== 4'd2) begin
      nFails++; $display("FAIL lives_round2: got state=%h vid=%0d rod=%0d want 3 3 2", db_estado, vidas_rest, rodada); end
    press(wrongOf(mem[0]));
    watchUntil(4'hC, 10, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL perde_vida: got %h want C", db_estado); end
    step();
    nChecks++; if (vidas_rest !== 3'd2 || db_estado !== 4'h9 || endereco !== 4'd0 || rodada !== 4'd2) begin
      nFails++; $display("FAIL replay_start: got vid=%0d state=%h end=%0d rod=%0d want 2 9 0 2", vidas_rest, db_estado, endereco, rodada); end
    pushRound(2);
    watchUntil(4'h3, 3500, ok);
    nChecks++; if (obsQ.size() != expQ.size()) begin
      nFails++; $display("FAIL replay_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nChecks++;
      if (o.val !== e.val || o.onLen != e.onLen || o.offLen != e.offLen || o.steady != e.steady) begin
        nFails++;
        $display("FAIL replay_item: got val=%h on=%0d off=%0d steady=%0d want val=%h on=%0d off=%0d steady=1",
                 o.val, o.onLen, o.offLen, o.steady, e.val, e.onLen, e.offLen);
      end
    end
    clearTrack();
    press(wrongOf(mem[0]));
    watchUntil(4'h9, 10, ok);
    nChecks++; if (!ok || vidas_rest !== 3'd1) begin
      nFails++; $display("FAIL second_error: got state=%h vid=%0d want 9 1", db_estado, vidas_rest); end
    watchUntil(4'h3, 3500, ok);
    press(wrongOf(mem[0]));
    watchUntil(4'hF, 10, ok);
    nChecks++; if (!ok || vidas_rest !== 3'd0 || {pronto, acertou, errou, fim_timeout} !== 4'b1010) begin
      nFails++; $display("FAIL third_error: got state=%h vid=%0d flags=%b want F 0 1010",
                         db_estado, vidas_rest, {pronto, acertou, errou, fim_timeout}); end
    clearTrack();
  endtask

  task automatic test_full_game();
    bit ok;
    item_t e, o;
    startGame(2'b00);
    for (int r = 0; r < 8; r++) begin
      pushRound(r);
      watchUntil(4'h3, (r + 1) * 1000 + 100, ok);
      nChecks++; if (!ok || rodada !== 4'(r)) begin
        nFails++; $display("FAIL game_round%0d: got state=%h rod=%0d want 3 %0d", r, db_estado, rodada, r); end
      nChecks++; if (obsQ.size() != expQ.size()) begin
        nFails++; $display("FAIL game_count_r%0d: got %0d want %0d", r, obsQ.size(), expQ.size()); end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
        e = expQ.pop_front(); o = obsQ.pop_front();
        nChecks++;
        if (o.val !== e.val || o.onLen != e.onLen || o.offLen != e.offLen || o.steady != e.steady) begin
          nFails++;
          $display("FAIL game_item_r%0d: got val=%h on=%0d off=%0d steady=%0d want val=%h on=%0d off=%0d steady=1",
                   r, o.val, o.onLen, o.offLen, o.steady, e.val, e.onLen, e.offLen);
        end
      end
      clearTrack();
      for (int i = 0; i <= r; i++) begin
        watchUntil(4'h3, 20, ok);
        nChecks++; if (!ok || endereco !== 4'(i)) begin
          nFails++; $display("FAIL game_play_r%0d_i%0d: got state=%h end=%0d want 3 %0d", r, i, db_estado, endereco, i); end
        press(mem[i]);
      end
    end
    watchUntil(4'hE, 20, ok);
    nChecks++; if (!ok || {pronto, acertou, errou, fim_timeout} !== 4'b1100 || rodada !== 4'd7) begin
      nFails++; $display("FAIL game_won: got state=%h flags=%b rod=%0d want E 1100 7",
                         db_estado, {pronto, acertou, errou, fim_timeout}, rodada); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << ((i * 5 + (i >> 2)) & 3));
    test_reset();
    test_round0_and_wrong();
    test_timeout();
    test_play_last_cycle();
    test_reset_in_espera();
    test_lives();
    modo = 2'b00;
    test_full_game();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sequenciador_jogo_param.md
SEQUENCIADOR_JOGO_PARAM -- requirements
Module: sequenciador_jogo_param

Interface
REQ-001 Parameter NB, default 4: number of buttons/LEDs and memory data width.
REQ-002 Parameter DEPTH, default 16: maximum rounds (power of 2, >=2); AW = clog2(DEPTH).
REQ-003 Parameter T_MOSTRA, default 500: LED-on cycles per displayed item.
REQ-004 Parameter T_INTERVALO, default 500: LED-off cycles between displayed items.
REQ-005 Parameter T_TIMEOUT, default 3000: cycles allowed per play.
REQ-006 Parameter VIDAS, default 3: lives when lives mode is enabled (1..7).
REQ-007 clock  in  1  system clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 iniciar  in  1  start / restart request.
REQ-010 botoes  in  NB  player buttons, level; at most one high at a time.
REQ-011 dado_mem  in  NB  one-hot sequence item at address endereco, valid combinationally.
REQ-012 modo  in  2  bit0: 0 = DEPTH/2 rounds, 1 = DEPTH rounds; bit1: 1 = lives mode.
REQ-013 endereco  out  AW  sequence memory address.
REQ-014 leds  out  NB  LED drive.
REQ-015 rodada  out  AW  current round index (0-based).
REQ-016 vidas_rest  out  3  remaining lives.
REQ-017 pronto, acertou, errou, fim_timeout  out  1 each  end-of-game flags.
REQ-018 db_estado  out  4  state code.

Function
REQ-019 State codes: INICIAL 0, PREPARACAO 1, PROXIMA_MOSTRA 2, ESPERA 3, REGISTRA 4, COMPARA 5, PROXIMA_JOGADA 6, ULTIMA 7, PROXIMA_SEQ 8, MOSTRA 9, INTERVALO A, INICIA_SEQ B, PERDE_VIDA C, FINAL_TIMEOUT D, FINAL_ACERTOU E, FINAL_ERROU F.
REQ-020 INICIAL -> PREPARACAO when iniciar=1; PREPARACAO clears rodada, endereco, timers, latches modo, loads vidas_rest = modo[1] ? VIDAS : 1; -> MOSTRA.
REQ-021 MOSTRA: leds = dado_mem for exactly T_MOSTRA cycles, then INTERVALO.
REQ-022 INTERVALO: leds = 0 for exactly T_INTERVALO cycles, then PROXIMA_MOSTRA.
REQ-023 PROXIMA_MOSTRA: endereco == rodada -> INICIA_SEQ (endereco cleared); else endereco+1 -> MOSTRA.
REQ-024 INICIA_SEQ -> ESPERA; timeout timer cleared on entry to ESPERA.
REQ-025 Play = rising edge of OR(botoes), detected via one registered copy; in ESPERA play -> REGISTRA capturing botoes.
REQ-026 ESPERA: timer reaching T_TIMEOUT-1 with no play -> FINAL_TIMEOUT; play in same cycle wins.
REQ-027 leds = botoes in ESPERA, REGISTRA, COMPARA; 0 in all states not listed in REQ-021.
REQ-028 COMPARA: match and endereco<rodada -> PROXIMA_JOGADA (endereco+1) -> ESPERA; match and endereco==rodada -> ULTIMA; mismatch -> PERDE_VIDA.
REQ-029 PERDE_VIDA: vidas_rest decremented; if new value 0 -> FINAL_ERROU; else endereco cleared -> MOSTRA, same rodada replayed.
REQ-030 ULTIMA: rodada == limit-1 (limit = DEPTH/2 or DEPTH per latched modo[0]) -> FINAL_ACERTOU; else -> PROXIMA_SEQ.
REQ-031 PROXIMA_SEQ: rodada+1, endereco cleared -> MOSTRA.
REQ-032 Final states hold until iniciar=1 -> PREPARACAO; pronto=1 in all three; acertou/errou/fim_timeout=1 only in E/F/D respectively.
REQ-033 modo changes after PREPARACAO have no effect until next PREPARACAO.
REQ-034 Counters never wrap: rodada <= DEPTH-1, vidas_rest never below 0.

Reset
REQ-035 reset=0 at a rising edge forces INICIAL from any state, mid-display or mid-play included.
REQ-036 After reset: endereco=0, rodada=0, vidas_rest=0, leds=0, all flags 0, db_estado=0, timers 0.

Verification
REQ-037 modo=00, correct plays all rounds -> FINAL_ACERTOU after rodada 7 (DEPTH=16), acertou=1, pronto=1.
REQ-038 Round 0 display -> leds=dado_mem exactly 500 cycles, then 0 exactly 500 cycles.
REQ-039 No play in ESPERA -> FINAL_TIMEOUT after 3000 cycles, fim_timeout=1; play on cycle 2999 -> REGISTRA instead.
REQ-040 modo=10, wrong play in round 2 -> PERDE_VIDA, vidas_rest 3->2, round 2 replayed from endereco 0; three errors -> FINAL_ERROU.
REQ-041 modo=00 wrong play -> FINAL_ERROU directly, errou=1, vidas_rest=0.
REQ-042 reset=0 during MOSTRA and during ESPERA -> next cycle db_estado=0, leds=0, all outputs per REQ-036.
